// File: rtl/vu_level_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vu_pkg (package)
//  Purpose  : Shared types and helpers for the VU level tracker: peak-hold
//             state encoding, default sizing constants, thermometer encoder.
//  Ports    : n/a (package)
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
package vu_pkg;

  typedef enum logic [1:0] {
    PK_IDLE = 2'd0,
    PK_HOLD = 2'd1,
    PK_FALL = 2'd2
  } pk_state_t;

  localparam int LEVEL_N_DEF    = 16;
  localparam int HOLD_TICKS_DEF = 8;

  // Widest bar supported (LEVEL_N <= 64); callers keep the low LEVEL_N bits.
  localparam int THERM_MAX = 64;

  // Thermometer code: bits [lvl-1:0] set, everything above cleared.
  function automatic logic [THERM_MAX-1:0] therm(input logic [6:0] lvl);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_MAX; i++) begin
      t[i] = (i < int'(lvl));
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vu_level_tracker_peak.sv
`default_nettype none
// ============================================================================
//  Module   : vu_peak_hold
//  Purpose  : Peak-hold marker. Tracks the highest bar level, holds it for
//             HOLD_TICKS decay ticks, then lets it fall one level per tick
//             (never below the live level) until it returns to idle.
//  Ports    : clk  in   system clock
//             rst  in   synchronous active-high reset
//             tick in   single-cycle decay strobe
//             nxt  in   LVW  level being registered this cycle
//             peak out  LVW  held peak level (registered)
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
module vu_peak_hold
  import vu_pkg::*;
#(
  parameter int LVW        = 5,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [LVW-1:0] nxt,
  output logic [LVW-1:0] peak
);

  localparam int HCW = $clog2(HOLD_TICKS + 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_TICKS);

  pk_state_t      state, state_nxt;
  logic [LVW-1:0] peak_nxt;
  logic [LVW-1:0] peak_dec;
  logic [LVW-1:0] fall_val;
  logic [HCW-1:0] hold_cnt, hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PK_IDLE;
      peak     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      peak     <= peak_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Falling peak never drops below the live level, keeping peak >= level.
  // Only used in PK_FALL where peak > nxt >= 0, so peak - 1 cannot wrap.
  always_comb begin
    peak_dec = peak - LVW'(1);
    fall_val = (peak_dec > nxt) ? peak_dec : nxt;
  end

  always_comb begin
    state_nxt = state;
    peak_nxt  = peak;
    hold_nxt  = hold_cnt;
    case (state)
      PK_IDLE: begin
        if (nxt != '0) begin
          peak_nxt  = nxt;
          hold_nxt  = HOLD_LOAD;
          state_nxt = PK_HOLD;
        end
      end
      PK_HOLD: begin
        if (nxt >= peak) begin
          peak_nxt = nxt;
          hold_nxt = HOLD_LOAD;
        end else if (tick) begin
          hold_nxt = (hold_cnt != '0) ? hold_cnt - HCW'(1) : '0;
          if (hold_cnt <= HCW'(1)) begin
            state_nxt = PK_FALL;
          end
        end
      end
      PK_FALL: begin
        if (nxt >= peak) begin
          peak_nxt  = nxt;
          hold_nxt  = HOLD_LOAD;
          state_nxt = PK_HOLD;
        end else if (tick) begin
          peak_nxt = fall_val;
          if (fall_val == '0) begin
            state_nxt = PK_IDLE;
          end
        end
      end
      default: begin
        state_nxt = PK_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vu_level_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : vu_level_tracker
//  Purpose  : VU meter level tracker. Quantises sample magnitudes to a bar
//             level with instant attack and tick-paced decay, drives an LED
//             thermometer, a peak-hold marker and a clip flag.
//  Ports    : clk          in   system clock
//             rst          in   synchronous active-high reset
//             tick         in   single-cycle decay strobe
//             sample_valid in   sample qualifier
//             sample       in   SAMPLE_W unsigned magnitude
//             level        out  LVW current bar level 0..LEVEL_N
//             peak         out  LVW held peak level (>= level)
//             bar          out  LEVEL_N LED pattern, bit0 = lowest LED
//             clip         out  full-scale seen within HOLD_TICKS ticks
//  Config   : VU_PEAK_DOT_EN - when defined, the LED at the peak level is
//             lit on top of the level thermometer.
//  Revision : 1.0 - initial release
// ============================================================================
module vu_level_tracker
  import vu_pkg::*;
#(
  parameter  int SAMPLE_W   = 10,
  parameter  int LEVEL_N    = LEVEL_N_DEF,
  parameter  int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter  int DECAY_STEP = 1,
  localparam int LW         = $clog2(LEVEL_N),
  localparam int LVW        = LW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [LVW-1:0]      level,
  output logic [LVW-1:0]      peak,
  output logic [LEVEL_N-1:0]  bar,
  output logic                clip
);

  localparam int CCW = $clog2(HOLD_TICKS + 1);
  localparam logic [CCW-1:0] CLIP_LOAD = CCW'(HOLD_TICKS);

  logic [LVW-1:0]       lvl_in;
  logic [LVW-1:0]       valid_lvl;
  logic [LVW-1:0]       decayed;
  logic [LVW-1:0]       nxt;
  logic                 full_scale;
  logic [THERM_MAX-1:0] therm_nxt;
  logic [LEVEL_N-1:0]   bar_nxt;
  logic [LEVEL_N-1:0]   bar_base;
  logic [CCW-1:0]       clip_cnt;

  // Top LW bits of the sample plus one, so any non-zero sample lights at
  // least one LED and full scale lands exactly on LEVEL_N.
  always_comb begin
    lvl_in    = (sample == '0) ? '0 : ({1'b0, sample[SAMPLE_W-1 -: LW]} + LVW'(1));
    valid_lvl = sample_valid ? lvl_in : '0;
  end

  // Decay first, then instant attack via max.
  always_comb begin
    if (tick) begin
      decayed = (int'(level) > DECAY_STEP) ? level - LVW'(DECAY_STEP) : '0;
    end else begin
      decayed = level;
    end
    nxt = (valid_lvl > decayed) ? valid_lvl : decayed;
  end

  always_comb begin
    full_scale = sample_valid && (&sample);
    therm_nxt  = therm(7'(nxt));
    bar_nxt    = therm_nxt[LEVEL_N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= '0;
      bar_base <= '0;
      clip     <= 1'b0;
      clip_cnt <= '0;
    end else begin
      level    <= nxt;
      bar_base <= bar_nxt;
      // A fresh full-scale sample reloads and beats a same-cycle tick.
      if (full_scale) begin
        clip     <= 1'b1;
        clip_cnt <= CLIP_LOAD;
      end else if (tick && (clip_cnt != '0)) begin
        clip_cnt <= clip_cnt - CCW'(1);
        if (clip_cnt == CCW'(1)) begin
          clip <= 1'b0;
        end
      end
    end
  end

  vu_peak_hold #(
    .LVW        (LVW),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_peak (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .nxt  (nxt),
    .peak (peak)
  );

`ifdef VU_PEAK_DOT_EN
  // One-hot dot at position peak-1; both operands are registers, so the
  // overlay adds no extra latency.
  logic [LEVEL_N-1:0] dot;
  always_comb begin
    for (int i = 0; i < LEVEL_N; i++) begin
      dot[i] = (peak == LVW'(i + 1));
    end
    bar = bar_base | dot;
  end
`else
  assign bar = bar_base;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vu_level_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vu_level_tracker
//  Purpose  : Directed self-checking bench for vu_level_tracker (defaults).
//             Expected values are queued when stimulus is applied and
//             compared once the registered outputs update.
//  Config   : honours VU_PEAK_DOT_EN for bar expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vu_level_tracker;

`ifdef VU_PEAK_DOT_EN
  localparam bit DOT_EN = 1'b1;
`else
  localparam bit DOT_EN = 1'b0;
`endif

  localparam int SEL_LEVEL = 0;
  localparam int SEL_PEAK  = 1;
  localparam int SEL_BAR   = 2;
  localparam int SEL_CLIP  = 3;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        sample_valid;
  logic [9:0]  sample;
  logic [4:0]  level;
  logic [4:0]  peak;
  logic [15:0] bar;
  logic        clip;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  vu_level_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .peak         (peak),
    .bar          (bar),
    .clip         (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_bar(input int lv, input int pk);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) if (i < lv) b[i] = 1'b1;
    if (DOT_EN && pk > 0) b[pk-1] = 1'b1;
    return int'(b);
  endfunction

  task automatic expect_val(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input int lv, input int pk, input int cl);
    expect_val({tag, ".level"}, SEL_LEVEL, lv);
    expect_val({tag, ".peak"},  SEL_PEAK,  pk);
    expect_val({tag, ".bar"},   SEL_BAR,   exp_bar(lv, pk));
    expect_val({tag, ".clip"},  SEL_CLIP,  cl);
  endtask

  // Apply one cycle of stimulus, then score everything queued for it.
  task automatic cycle(input bit t, input bit v, input int s);
    exp_t e;
    int   obs;
    tick         = t;
    sample_valid = v;
    sample       = 10'(s);
    @(posedge clk);
    #1;
    tick         = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_LEVEL: obs = int'(level);
        SEL_PEAK:  obs = int'(peak);
        SEL_BAR:   obs = int'(bar);
        default:   obs = int'(clip);
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", e.tag, obs, obs, e.val, e.val);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    tick         = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0);
    expect_all("reset", 0, 0, 0);
    cycle(0, 0, 0);
    rst = 1'b0;

    // Smallest non-zero sample, then a valid zero sample
    expect_all("min_sample", 1, 1, 0);
    cycle(0, 1, 1);
    expect_val("zero_sample.level", SEL_LEVEL, 1);
    cycle(0, 1, 0);

    // Test 1: attack
    expect_all("attack", 9, 9, 0);
    cycle(0, 1, 512);

    // Test 2: decay and peak hold/fall
    for (int k = 1; k <= 17; k++) begin
      int lv, pk;
      lv = (9 - k > 0) ? 9 - k : 0;
      pk = (k <= 8) ? 9 : 17 - k;
      expect_all($sformatf("decay_t%0d", k), lv, pk, 0);
      cycle(1, 0, 0);
    end
    expect_all("idle_tick", 0, 0, 0);
    cycle(1, 0, 0);

    // Test 3: simultaneous tick and sample
    expect_val("sim_pre.level", SEL_LEVEL, 9);
    cycle(0, 1, 575);
    expect_val("sim_447.level", SEL_LEVEL, 8);
    expect_val("sim_447.peak",  SEL_PEAK,  9);
    cycle(1, 1, 447);
    expect_val("sim_reload.level", SEL_LEVEL, 9);
    cycle(0, 1, 575);
    expect_val("sim_575.level", SEL_LEVEL, 9);
    cycle(1, 1, 575);

    // Test 5: peak dot with level 3, peak 9
    for (int k = 1; k <= 5; k++) cycle(1, 0, 0);
    expect_val("dot.level", SEL_LEVEL, 3);
    expect_val("dot.peak",  SEL_PEAK,  9);
    expect_val("dot.bar",   SEL_BAR,   DOT_EN ? 32'h0107 : 32'h0007);
    cycle(1, 0, 0);

    // Test 4a: clip holds for 8 ticks
    expect_all("clip_set", 16, 16, 1);
    cycle(0, 1, 1023);
    for (int k = 1; k <= 8; k++) begin
      expect_val($sformatf("clip_a_t%0d.clip", k), SEL_CLIP, (k < 8) ? 1 : 0);
      expect_val($sformatf("clip_a_t%0d.level", k), SEL_LEVEL, 16 - k);
      cycle(1, 0, 0);
    end

    // Test 4b: re-trigger at tick 5 extends clip to tick 13
    expect_val("clip_b_set.clip", SEL_CLIP, 1);
    cycle(0, 1, 1023);
    for (int k = 1; k <= 13; k++) begin
      expect_val($sformatf("clip_b_t%0d.clip", k), SEL_CLIP, (k < 13) ? 1 : 0);
      expect_val($sformatf("clip_b_t%0d.level", k), SEL_LEVEL, (k < 5) ? 16 - k : 16 - (k - 5));
      if (k == 5) cycle(1, 1, 1023);
      else        cycle(1, 0, 0);
    end

    // Test 6: reset mid-operation, tick and sample during reset ignored
    cycle(0, 1, 1023);
    for (int k = 1; k <= 3; k++) cycle(1, 0, 0);
    expect_val("pre_rst.level", SEL_LEVEL, 12);
    expect_val("pre_rst.clip",  SEL_CLIP,  1);
    cycle(1, 0, 0);
    rst = 1'b1;
    expect_all("mid_rst", 0, 0, 0);
    cycle(1, 1, 1023);
    rst = 1'b0;
    expect_all("post_rst", 0, 0, 0);
    cycle(0, 0, 0);
    expect_all("post_rst_tick", 0, 0, 0);
    cycle(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
